// File: rtl/regfile_writeback_queue_pkg.sv
// Shared definitions for the register-file writeback path.
//   REG_AW     : register address width (32 architectural registers)
//   XZR_IDX    : hard-wired zero register; writes to it are dropped
//   wb_entry_t : {rd, data} writeback record carried by the pipeline stages
package regfile_writeback_queue_pkg;
  localparam int                REG_AW  = 5;
  localparam logic [REG_AW-1:0] XZR_IDX = 5'd31;
  localparam int                WB_DW   = 64;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [WB_DW-1:0]  data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_queue_fwd_match.sv
// Youngest-match forwarding scan over the writeback queue storage.
//   tail_i : queue tail pointer (next free slot)
//   vld_i  : per-slot occupancy mask
//   rd_i   : per-slot destination register
//   data_i : per-slot result data
//   look_i : register being looked up
//   hit_o  : some pending entry targets look_i
//   fwd_o  : data of the youngest such entry, 0 when no hit
module wbq_fwd_match
  import regfile_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = 64,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic [PW-1:0]                  tail_i,
  input  logic [DEPTH-1:0]               vld_i,
  input  logic [DEPTH-1:0][REG_AW-1:0]   rd_i,
  input  logic [DEPTH-1:0][DW-1:0]       data_i,
  input  logic [REG_AW-1:0]              look_i,
  output logic                           hit_o,
  output logic [DW-1:0]                  fwd_o
);

  logic [PW-1:0] idx;

  // Walk from the oldest slot (tail-DEPTH) to the youngest (tail-1); later
  // matches overwrite earlier ones so the youngest entry wins.
  always_comb begin
    hit_o = 1'b0;
    fwd_o = '0;
    idx   = '0;
    for (int i = DEPTH; i >= 1; i--) begin
      idx = tail_i - PW'(i);
      if (vld_i[idx] && (rd_i[idx] == look_i) && (look_i != XZR_IDX)) begin
        hit_o = 1'b1;
        fwd_o = data_i[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue in front of the register file write port.
//   Clk, ResetL               : clock, async active-low reset
//   MemValid/MemRd/MemData    : memory-stage (older) writeback request
//   MemReady                  : memory request accepted when valid
//   ExValid/ExRd/ExData       : execute-stage (younger) writeback request
//   ExReady                   : execute request accepted when valid
//   RW/BusW/RegWr             : register file write port, driven from head
//   LookA/B, HitA/B, FwdA/B   : forwarding lookups over pending entries
//   Count/Full/Empty          : occupancy status
module regfile_writeback_queue
  import regfile_writeback_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  parameter  int DW    = 64,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              Clk,
  input  logic              ResetL,
  input  logic              MemValid,
  input  logic [REG_AW-1:0] MemRd,
  input  logic [DW-1:0]     MemData,
  output logic              MemReady,
  input  logic              ExValid,
  input  logic [REG_AW-1:0] ExRd,
  input  logic [DW-1:0]     ExData,
  output logic              ExReady,
  output logic [REG_AW-1:0] RW,
  output logic [DW-1:0]     BusW,
  output logic              RegWr,
  input  logic [REG_AW-1:0] LookA,
  output logic              HitA,
  output logic [DW-1:0]     FwdA,
  input  logic [REG_AW-1:0] LookB,
  output logic              HitB,
  output logic [DW-1:0]     FwdB,
  output logic [CW-1:0]     Count,
  output logic              Full,
  output logic              Empty
);

  logic [PW-1:0]                head_q, head_d, tail_q, tail_d, ex_slot;
  logic [CW-1:0]                count_q, count_d, free;
  logic [DEPTH-1:0][REG_AW-1:0] rd_q;
  logic [DEPTH-1:0][DW-1:0]     data_q;
  logic [DEPTH-1:0]             vld;
  logic [PW-1:0]                off;
  logic                         mem_push, ex_push, pop;
  logic [1:0]                   npush;

  // Space is judged on registered Count only; a same-cycle pop never frees
  // a slot, which keeps Ready independent of the drain path.
  assign free     = CW'(DEPTH) - count_q;
  assign MemReady = (free != '0);
  assign ExReady  = MemValid ? (free >= CW'(2)) : (free != '0);

  // XZR writes complete the handshake but allocate nothing.
  assign mem_push = MemValid & MemReady & (MemRd != XZR_IDX);
  assign ex_push  = ExValid  & ExReady  & (ExRd  != XZR_IDX);
  assign npush    = {1'b0, mem_push} + {1'b0, ex_push};
  assign pop      = (count_q != '0);

  // Ex lands behind Mem when both allocate, else at the tail itself.
  assign ex_slot  = tail_q + PW'(mem_push);
  assign head_d   = head_q + PW'(pop);
  assign tail_d   = tail_q + PW'(npush);
  assign count_d  = count_q + CW'(npush) - CW'(pop);

  // Slot s is occupied when its distance from head is below Count.
  always_comb begin
    vld = '0;
    off = '0;
    for (int s = 0; s < DEPTH; s++) begin
      off    = PW'(s) - head_q;
      vld[s] = (CW'(off) < count_q);
    end
  end

  always_ff @(posedge Clk or negedge ResetL) begin
    if (!ResetL) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int s = 0; s < DEPTH; s++) begin
        if (mem_push && (PW'(s) == tail_q)) begin
          rd_q[s]   <= MemRd;
          data_q[s] <= MemData;
        end else if (ex_push && (PW'(s) == ex_slot)) begin
          rd_q[s]   <= ExRd;
          data_q[s] <= ExData;
        end
      end
    end
  end

  assign RegWr = pop;
  assign RW    = pop ? rd_q[head_q]   : '0;
  assign BusW  = pop ? data_q[head_q] : '0;
  assign Count = count_q;
  assign Full  = (count_q == CW'(DEPTH));
  assign Empty = !pop;

  logic [1:0][REG_AW-1:0] look;
  logic [1:0]             hit;
  logic [1:0][DW-1:0]     fwd;

  assign look = {LookB, LookA};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    wbq_fwd_match #(.DEPTH(DEPTH), .DW(DW), .PW(PW)) u_match (
      .tail_i (tail_q),
      .vld_i  (vld),
      .rd_i   (rd_q),
      .data_i (data_q),
      .look_i (look[g]),
      .hit_o  (hit[g]),
      .fwd_o  (fwd[g])
    );
  end

  assign HitA = hit[0];
  assign FwdA = fwd[0];
  assign HitB = hit[1];
  assign FwdB = fwd[1];

endmodule

// File: tb/tb_regfile_writeback_queue.sv
module tb_regfile_writeback_queue;

  logic        Clk = 1'b0;
  logic        ResetL;
  // DEPTH=4 instance
  logic        MemValid, ExValid, MemReady, ExReady, RegWr, HitA, HitB, Full, Empty;
  logic [4:0]  MemRd, ExRd, RW, LookA, LookB;
  logic [63:0] MemData, ExData, BusW, FwdA, FwdB;
  logic [2:0]  Count;
  // DEPTH=2 instance (only way to reach Full, since the head drains every cycle)
  logic        m2v, e2v, m2rdy, e2rdy, wr2, hitA2, hitB2, full2, empty2;
  logic [4:0]  m2rd, e2rd, rw2, lookA2, lookB2;
  logic [63:0] m2d, e2d, busw2, fwdA2, fwdB2;
  logic [1:0]  cnt2;

  int n_chk = 0;
  int n_pass = 0;

  always #5 Clk = ~Clk;

  regfile_writeback_queue #(.DEPTH(4), .DW(64)) u_dut (
    .Clk(Clk), .ResetL(ResetL),
    .MemValid(MemValid), .MemRd(MemRd), .MemData(MemData), .MemReady(MemReady),
    .ExValid(ExValid), .ExRd(ExRd), .ExData(ExData), .ExReady(ExReady),
    .RW(RW), .BusW(BusW), .RegWr(RegWr),
    .LookA(LookA), .HitA(HitA), .FwdA(FwdA),
    .LookB(LookB), .HitB(HitB), .FwdB(FwdB),
    .Count(Count), .Full(Full), .Empty(Empty)
  );

  regfile_writeback_queue #(.DEPTH(2), .DW(64)) u_dut2 (
    .Clk(Clk), .ResetL(ResetL),
    .MemValid(m2v), .MemRd(m2rd), .MemData(m2d), .MemReady(m2rdy),
    .ExValid(e2v), .ExRd(e2rd), .ExData(e2d), .ExReady(e2rdy),
    .RW(rw2), .BusW(busw2), .RegWr(wr2),
    .LookA(lookA2), .HitA(hitA2), .FwdA(fwdA2),
    .LookB(lookB2), .HitB(hitB2), .FwdB(fwdB2),
    .Count(cnt2), .Full(full2), .Empty(empty2)
  );

  // Register file model behind the write port; X31 is never stored.
  logic [63:0] rf [32] = '{default: '0};
  logic        xzr_wr = 1'b0;
  always @(posedge Clk) begin
    if (RegWr && RW != 5'd31) rf[RW] <= BusW;
    if (RegWr && RW == 5'd31) xzr_wr <= 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    MemValid = 1'b0; ExValid = 1'b0; m2v = 1'b0; e2v = 1'b0;
  endtask

  logic [63:0] s12, s13, s14;
  logic [63:0] exp_rf [32];
  int          cnt;
  logic        mf, ef;

  initial begin
    ResetL = 1'b0;
    idle();
    MemRd = '0; ExRd = '0; MemData = '0; ExData = '0; LookA = '0; LookB = '0;
    m2rd = '0; e2rd = '0; m2d = '0; e2d = '0; lookA2 = '0; lookB2 = '0;
    #2;
    // reset state
    chk("rst_regwr", RegWr, 0);
    chk("rst_rw",    RW,    0);
    chk("rst_busw",  BusW,  0);
    chk("rst_empty", Empty, 1);
    chk("rst_full",  Full,  0);
    chk("rst_count", Count, 0);
    chk("rst_hita",  HitA,  0);
    chk("rst_fwda",  FwdA,  0);
    chk("rst_mrdy",  MemReady, 1);
    @(negedge Clk); ResetL = 1'b1;
    cyc();

    // single write
    MemValid = 1; MemRd = 5; MemData = 64'hA5; LookA = 5; #1;
    chk("sw_hit_pre", HitA, 0);
    cyc(); idle(); #1;
    chk("sw_regwr", RegWr, 1);
    chk("sw_rw",    RW,    5);
    chk("sw_busw",  BusW,  64'hA5);
    chk("sw_count", Count, 1);
    chk("sw_hita",  HitA,  1);
    chk("sw_fwda",  FwdA,  64'hA5);
    cyc(); #1;
    chk("sw_regwr_after", RegWr, 0);
    chk("sw_empty", Empty, 1);
    chk("sw_rf5",   rf[5], 64'hA5);

    // dual push, same rd
    MemValid = 1; MemRd = 3; MemData = 64'h11;
    ExValid  = 1; ExRd  = 3; ExData  = 64'h22; LookA = 3; LookB = 4; #1;
    chk("dp_exrdy", ExReady, 1);
    cyc(); idle(); #1;
    chk("dp_count0", Count, 2);
    chk("dp_rw0",    RW,    3);
    chk("dp_busw0",  BusW,  64'h11);
    chk("dp_hita",   HitA,  1);
    chk("dp_fwda",   FwdA,  64'h22);
    chk("dp_hitb",   HitB,  0);
    cyc(); #1;
    chk("dp_count1", Count, 1);
    chk("dp_rw1",    RW,    3);
    chk("dp_busw1",  BusW,  64'h22);
    chk("dp_fwda1",  FwdA,  64'h22);
    cyc(); #1;
    chk("dp_empty",  Empty, 1);
    chk("dp_rf3",    rf[3], 64'h22);
    chk("dp_hita_e", HitA,  0);

    // fill towards the top of a DEPTH=4 queue
    MemValid = 1; MemRd = 1; MemData = 64'h101; ExValid = 1; ExRd = 2; ExData = 64'h102;
    cyc();
    MemRd = 4; MemData = 64'h104; ExRd = 6; ExData = 64'h106; #1;
    chk("fl_exrdy_f2", ExReady, 1);
    cyc();
    MemRd = 7; MemData = 64'h107; ExRd = 8; ExData = 64'h108; #1;
    chk("fl_count3", Count, 3);
    chk("fl_full3",  Full,  0);
    chk("fl_mrdy_f1", MemReady, 1);
    chk("fl_exrdy_f1", ExReady, 0);
    MemValid = 0; #1;
    chk("fl_exrdy_nomem", ExReady, 1);
    MemValid = 1; ExValid = 0;
    cyc(); idle(); LookA = 6; LookB = 7; #1;
    chk("fl_count_hold", Count, 3);
    chk("fl_rw_head", RW, 4);
    chk("fl_fwda6", FwdA, 64'h106);
    chk("fl_fwdb7", FwdB, 64'h107);
    cyc(); cyc(); cyc(); #1;
    chk("fl_empty", Empty, 1);
    chk("fl_rf1", rf[1], 64'h101);
    chk("fl_rf7", rf[7], 64'h107);
    chk("fl_rf8_untouched", rf[8], 0);

    // Full on DEPTH=2
    m2v = 1; m2rd = 9; m2d = 64'h9; e2v = 1; e2rd = 10; e2d = 64'hA; lookA2 = 10; lookB2 = 9; #1;
    chk("d2_exrdy", e2rdy, 1);
    cyc(); idle(); #1;
    chk("d2_count", cnt2, 2);
    chk("d2_full",  full2, 1);
    chk("d2_mrdy",  m2rdy, 0);
    chk("d2_rw",    rw2, 9);
    chk("d2_busw",  busw2, 64'h9);
    chk("d2_fwda",  fwdA2, 64'hA);
    chk("d2_fwdb",  fwdB2, 64'h9);
    m2v = 1; e2v = 1; #1;
    chk("d2_exrdy_full", e2rdy, 0);
    idle();
    cyc(); cyc(); #1;
    chk("d2_empty", empty2, 1);
    chk("d2_regwr", wr2, 0);

    // XZR
    ExValid = 1; ExRd = 31; ExData = 64'hDEADBEEF; LookA = 31; #1;
    chk("xz_exrdy", ExReady, 1);
    cyc(); idle(); #1;
    chk("xz_count", Count, 0);
    chk("xz_regwr", RegWr, 0);
    chk("xz_hita",  HitA,  0);
    MemValid = 1; MemRd = 31; MemData = 64'h55; ExValid = 1; ExRd = 9; ExData = 64'h99;
    cyc(); idle(); #1;
    chk("xz_mix_count", Count, 1);
    chk("xz_mix_rw",    RW, 9);
    cyc(); #1;
    chk("xz_mix_rf9",   rf[9], 64'h99);

    // async reset with pending entries
    MemValid = 1; MemRd = 11; MemData = 64'hB1; ExValid = 1; ExRd = 12; ExData = 64'hB2;
    cyc();
    MemRd = 13; MemData = 64'hB3; ExRd = 14; ExData = 64'hB4;
    cyc(); idle(); LookA = 14; #1;
    chk("ro_count3", Count, 3);
    chk("ro_hita",   HitA,  1);
    s12 = rf[12]; s13 = rf[13]; s14 = rf[14];
    #2; ResetL = 1'b0; #1;
    chk("ro_regwr", RegWr, 0);
    chk("ro_count", Count, 0);
    chk("ro_hita0", HitA,  0);
    chk("ro_empty", Empty, 1);
    cyc(); cyc();
    @(negedge Clk); ResetL = 1'b1;
    cyc(); cyc(); #1;
    chk("ro_rf11", rf[11], 64'hB1);
    chk("ro_rf12", rf[12], s12);
    chk("ro_rf13", rf[13], s13);
    chk("ro_rf14", rf[14], s14);

    // random traffic against a register scoreboard
    for (int r = 0; r < 32; r++) exp_rf[r] = rf[r];
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      MemValid = 1'($urandom_range(0, 1));
      ExValid  = 1'($urandom_range(0, 1));
      MemRd    = 5'($urandom_range(0, 31));
      ExRd     = 5'($urandom_range(0, 31));
      MemData  = {$urandom, $urandom};
      ExData   = {$urandom, $urandom};
      #1;
      chk("rn_count", Count, 64'(cnt));
      chk("rn_mrdy",  MemReady, (cnt < 4));
      chk("rn_exrdy", ExReady,  MemValid ? (cnt <= 2) : (cnt < 4));
      mf = MemValid && (cnt < 4);
      ef = ExValid && (MemValid ? (cnt <= 2) : (cnt < 4));
      if (cnt != 0) cnt--;
      if (mf && MemRd != 31) begin exp_rf[MemRd] = MemData; cnt++; end
      if (ef && ExRd  != 31) begin exp_rf[ExRd]  = ExData;  cnt++; end
      cyc();
    end
    idle();
    for (int k = 0; k < 6; k++) cyc();
    chk("rn_drained", Empty, 1);
    for (int r = 0; r < 31; r++) chk($sformatf("rn_rf%0d", r), rf[r], exp_rf[r]);
    chk("xzr_never_written", xzr_wr, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
